// File: rtl/div8b_seq_pkg.sv
// Shared definitions for the sequential restoring divider: state codes and default width.
package div8b_seq_pkg;

  localparam int unsigned DIV_DATASIZE = 8;
  localparam int unsigned DIV_STATE_W  = 2;

  typedef enum logic [DIV_STATE_W-1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div8b_seq_sub.sv
// Ripple-borrow subtractor: oD = iA - iM - borrow_in, with per-bit borrow-out and propagate.
module sub8b #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned USE_EXTB = 1
) (
  input  logic [DATASIZE-1:0] iA,
  input  logic [DATASIZE-1:0] iM,
  input  logic                iB,
  output logic [DATASIZE-1:0] oD,
  output logic [DATASIZE-1:0] oB,
  output logic [DATASIZE-1:0] oP
);

  logic [DATASIZE:0] bchain;

  always_comb begin
    oD     = '0;
    oB     = '0;
    oP     = '0;
    bchain = '0;
    // External borrow-in only when the instance asks for it
    bchain[0] = (USE_EXTB != 0) ? iB : 1'b0;
    for (int i = 0; i < int'(DATASIZE); i++) begin
      oP[i]       = iA[i] ^ iM[i];
      oD[i]       = oP[i] ^ bchain[i];
      bchain[i+1] = (~iA[i] & iM[i]) | (~oP[i] & bchain[i]);
      oB[i]       = bchain[i+1];
    end
  end

endmodule

// File: rtl/div8b_seq.sv
// Unsigned restoring divider: one trial subtraction per clock, DATASIZE iterations per divide.
module div8b_seq
  import div8b_seq_pkg::*;
#(
  parameter int unsigned DATASIZE = DIV_DATASIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [DATASIZE-1:0] iDvd,
  input  logic [DATASIZE-1:0] iDvs,
  output logic                oBusy,
  output logic                oDone,
  output logic [DATASIZE-1:0] oQuo,
  output logic [DATASIZE-1:0] oRem,
  output logic                oDivZ
);

  localparam int unsigned CNT_W = $clog2(DATASIZE + 1);

  div_state_e          state_q, state_d;
  logic [DATASIZE:0]   a_q, a_d;
  logic [DATASIZE-1:0] q_q, q_d;
  logic [DATASIZE-1:0] m_q, m_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                divz_flag_q, divz_flag_d;
  logic                busy_d, done_d, divz_d;
  logic [DATASIZE-1:0] quo_d, rem_d;

  logic [DATASIZE:0]   trial_s;
  logic [DATASIZE:0]   trial_d;
  logic [DATASIZE:0]   trial_b;
  logic [DATASIZE:0]   trial_p;
  logic                trial_borrow;
  logic [2*DATASIZE+2:0] unused_bits;

  // Shift the next dividend bit into the partial remainder and trial-subtract the divisor
  assign trial_s      = {a_q[DATASIZE-1:0], q_q[DATASIZE-1]};
  assign trial_borrow = trial_b[DATASIZE];
  assign unused_bits  = {a_q[DATASIZE], trial_p, trial_b[DATASIZE-1:0]};

  sub8b #(
    .DATASIZE (DATASIZE + 1),
    .USE_EXTB (0)
  ) trial (
    .iA (trial_s),
    .iM ({1'b0, m_q}),
    .iB (1'b0),
    .oD (trial_d),
    .oB (trial_b),
    .oP (trial_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      divz_flag_q <= 1'b0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oQuo        <= '0;
      oRem        <= '0;
      oDivZ       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      cnt_q       <= cnt_d;
      divz_flag_q <= divz_flag_d;
      oBusy       <= busy_d;
      oDone       <= done_d;
      oQuo        <= quo_d;
      oRem        <= rem_d;
      oDivZ       <= divz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    cnt_d       = cnt_q;
    divz_flag_d = divz_flag_q;
    busy_d      = oBusy;
    done_d      = oDone;
    quo_d       = oQuo;
    rem_d       = oRem;
    divz_d      = oDivZ;

    case (state_q)
      DIV_IDLE: begin
        done_d = 1'b0;
        busy_d = iStart;
        if (iStart) begin
          if (iDvs != '0) begin
            q_d         = iDvd;
            a_d         = '0;
            m_d         = iDvs;
            cnt_d       = CNT_W'(DATASIZE);
            divz_flag_d = 1'b0;
            state_d     = DIV_CALC;
          end else begin
            // Zero divisor: skip iterations, report all-ones quotient and dividend as remainder
            q_d         = '1;
            a_d         = {1'b0, iDvd};
            divz_flag_d = 1'b1;
            state_d     = DIV_DONE;
          end
        end
      end
      DIV_CALC: begin
        done_d = 1'b0;
        busy_d = 1'b1;
        if (trial_borrow) begin
          a_d = trial_s;
          q_d = {q_q[DATASIZE-2:0], 1'b0};
        end else begin
          a_d = trial_d;
          q_d = {q_q[DATASIZE-2:0], 1'b1};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        quo_d   = q_q;
        rem_d   = a_q[DATASIZE-1:0];
        divz_d  = divz_flag_q;
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div8b_seq.sv
// Directed and randomly sampled checks of the sequential divider against hand-computed results.
module tb_div8b_seq;

  logic       clk;
  logic       rst;
  logic       iStart;
  logic [7:0] iDvd;
  logic [7:0] iDvs;
  logic       oBusy;
  logic       oDone;
  logic [7:0] oQuo;
  logic [7:0] oRem;
  logic       oDivZ;

  int errors;
  int checks;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] quo;
    logic [7:0] rem;
    logic       divz;
    int         lat;
    int         busy;
  } vec_t;

  vec_t vecs[8];

  div8b_seq dut (
    .clk    (clk),
    .rst    (rst),
    .iStart (iStart),
    .iDvd   (iDvd),
    .iDvs   (iDvs),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oQuo   (oQuo),
    .oRem   (oRem),
    .oDivZ  (oDivZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one cycle; the edge at the end of that cycle is the accept edge
  task automatic start_div(input logic [7:0] dvd, input logic [7:0] dvs);
    iStart = 1'b1;
    iDvd   = dvd;
    iDvs   = dvs;
    step();
    iStart = 1'b0;
    iDvd   = 8'($urandom);
    iDvs   = 8'($urandom);
  endtask

  // Count edges until oDone, and busy cycles seen on the way
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!oDone && lat < 40) begin
      if (oBusy) bcnt++;
      step();
      lat++;
    end
    if (!oDone) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: got oDone=0 expected 1 within 40 cycles");
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    logic [7:0] a;
    logic [7:0] b;

    errors = 0;
    checks = 0;
    rst    = 1'b1;
    iStart = 1'b0;
    iDvd   = 8'd0;
    iDvs   = 8'd0;

    vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 9, 9};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, 9};
    vecs[2] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9, 9};
    vecs[3] = '{8'd128, 8'd129, 8'd0,   8'd128, 1'b0, 9, 9};
    vecs[4] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9, 9};
    vecs[5] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 9, 9};
    vecs[6] = '{8'd37,  8'd0,   8'hFF,  8'd37,  1'b1, 1, 1};
    vecs[7] = '{8'd10,  8'd3,   8'd3,   8'd1,   1'b0, 9, 9};

    step();
    step();
    chk("reset_busy", int'(oBusy), 0);
    chk("reset_done", int'(oDone), 0);
    chk("reset_quo",  int'(oQuo),  0);
    chk("reset_rem",  int'(oRem),  0);
    chk("reset_divz", int'(oDivZ), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      start_div(vecs[i].dvd, vecs[i].dvs);
      wait_done(lat, bcnt);
      chk($sformatf("v%0d_quo", i),  int'(oQuo),  int'(vecs[i].quo));
      chk($sformatf("v%0d_rem", i),  int'(oRem),  int'(vecs[i].rem));
      chk($sformatf("v%0d_divz", i), int'(oDivZ), int'(vecs[i].divz));
      chk($sformatf("v%0d_lat", i),  lat,         vecs[i].lat);
      chk($sformatf("v%0d_busy", i), bcnt,        vecs[i].busy);
      step();
      chk($sformatf("v%0d_done_pulse", i), int'(oDone), 0);
      chk($sformatf("v%0d_quo_hold", i),   int'(oQuo),  int'(vecs[i].quo));
    end

    // A start pulse during CALC must be ignored
    start_div(8'd100, 8'd9);
    step();
    step();
    iStart = 1'b1;
    iDvd   = 8'd50;
    iDvs   = 8'd5;
    step();
    iStart = 1'b0;
    wait_done(lat, bcnt);
    chk("ign_quo", int'(oQuo), 11);
    chk("ign_rem", int'(oRem), 1);
    chk("ign_lat", lat, 6);
    step();
    chk("ign_no_restart", int'(oBusy), 0);

    // Synchronous reset in the middle of a divide discards it
    start_div(8'd200, 8'd7);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", int'(oBusy), 0);
    chk("mid_rst_done", int'(oDone), 0);
    chk("mid_rst_quo",  int'(oQuo),  0);
    chk("mid_rst_rem",  int'(oRem),  0);
    chk("mid_rst_divz", int'(oDivZ), 0);
    step();
    chk("mid_rst_idle", int'(oBusy), 0);
    start_div(8'd200, 8'd7);
    wait_done(lat, bcnt);
    chk("post_rst_quo",  int'(oQuo), 28);
    chk("post_rst_rem",  int'(oRem), 4);
    chk("post_rst_lat",  lat, 9);
    chk("post_rst_busy", bcnt, 9);

    // Back-to-back issue: start in the oDone cycle
    start_div(8'd77, 8'd6);
    wait_done(lat, bcnt);
    chk("b2b_quo", int'(oQuo), 12);
    chk("b2b_rem", int'(oRem), 5);

    // Randomly sampled operand pairs against a reference divide
    for (int n = 0; n < 24; n++) begin
      a = 8'($urandom);
      b = (n % 6 == 5) ? 8'd0 : 8'($urandom);
      start_div(a, b);
      wait_done(lat, bcnt);
      if (b == 8'd0) begin
        chk($sformatf("rnd%0d_quo", n),  int'(oQuo),  255);
        chk($sformatf("rnd%0d_rem", n),  int'(oRem),  int'(a));
        chk($sformatf("rnd%0d_divz", n), int'(oDivZ), 1);
      end else begin
        chk($sformatf("rnd%0d_quo", n),  int'(oQuo),  int'(a) / int'(b));
        chk($sformatf("rnd%0d_rem", n),  int'(oRem),  int'(a) % int'(b));
        chk($sformatf("rnd%0d_divz", n), int'(oDivZ), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
